// File: rtl/vga_mem_pkg.sv
// Shared types for the VGA frame-memory arbiter: arbitration states, SRAM control
// bundle and the helper that maps a state onto active-low pin levels.
package vga_mem_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 16;

    typedef logic [DATA_W_DEF-1:0] mem_word_t;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_READ,
        ARB_WRITE
    } arb_state_t;

    typedef struct packed {
        logic ce_n;
        logic oe_n;
        logic we_n;
    } mem_ctrl_t;

    function automatic mem_ctrl_t ctrl_for(input arb_state_t s);
        mem_ctrl_t c;
        c = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1};
        case (s)
            ARB_READ:  c = '{ce_n: 1'b0, oe_n: 1'b0, we_n: 1'b1};
            ARB_WRITE: c = '{ce_n: 1'b0, oe_n: 1'b1, we_n: 1'b0};
            default:   c = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_rd_valid_pipe.sv
// Read-return delay line: tracks in-flight display reads and captures mem_rdata
// on the edge where each one completes.
module vga_rd_valid_pipe #(
    parameter int LAT    = 2,
    parameter int DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              launch_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              rvalid_o,
    output logic [DATA_W-1:0] rdata_o
);

    logic [LAT:0]        valid_q;
    logic [DATA_W-1:0]   rdata_q;

    // Stage LAT-1 set means the memory is presenting that read's data right now.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= '0;
            rdata_q <= '0;
        end else begin
            valid_q <= {valid_q[LAT-1:0], launch_i};
            if (valid_q[LAT-1]) begin
                rdata_q <= mem_rdata_i;
            end
        end
    end

    assign rvalid_o = valid_q[LAT];
    assign rdata_o  = rdata_q;

endmodule

// File: rtl/vga_mem_arbiter.sv
// Frame-memory arbiter: display reads always win, writer uses free cycles.
// Optional counters (rd_count, wr_count, max_wait) exist when VGA_MEM_ARB_STATS_EN is defined.
module vga_mem_arbiter
    import vga_mem_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int RD_LATENCY   = 2,
    parameter int STARVE_LIMIT = 64
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic              wr_starve,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ce_n,
    output logic              mem_oe_n,
    output logic              mem_we_n
`ifdef VGA_MEM_ARB_STATS_EN
    ,
    output logic [31:0]       rd_count,
    output logic [31:0]       wr_count,
    output logic [15:0]       max_wait
`endif
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t          state_q, state_d;
    mem_ctrl_t           ctrl_q;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [CNT_W-1:0]    wait_q, wait_d;

    // A write is never chosen in its own grant cycle, so held data is written once.
    always_comb begin
        state_d = ARB_IDLE;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (disp_req) begin
            state_d = ARB_READ;
            addr_d  = disp_addr;
        end else if (wr_req && !wr_gnt) begin
            state_d = ARB_WRITE;
            addr_d  = wr_addr;
            wdata_d = wr_data;
        end
    end

    always_comb begin
        wait_d = wait_q;
        if (!wr_req || wr_gnt) begin
            wait_d = '0;
        end else if (wait_q != CNT_W'(STARVE_LIMIT)) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ARB_IDLE;
            ctrl_q  <= ctrl_for(ARB_IDLE);
            addr_q  <= '0;
            wdata_q <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_for(state_d);
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wait_q  <= wait_d;
        end
    end

    assign mem_ce_n  = ctrl_q.ce_n;
    assign mem_oe_n  = ctrl_q.oe_n;
    assign mem_we_n  = ctrl_q.we_n;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign wr_gnt    = (state_q == ARB_WRITE);
    assign wr_starve = (wait_q == CNT_W'(STARVE_LIMIT));

    vga_rd_valid_pipe #(
        .LAT    (RD_LATENCY),
        .DATA_W (DATA_W)
    ) u_rd_pipe (
        .clk_i       (Clk),
        .reset_i     (Reset),
        .launch_i    (disp_req),
        .mem_rdata_i (mem_rdata),
        .rvalid_o    (disp_rvalid),
        .rdata_o     (disp_rdata)
    );

`ifdef VGA_MEM_ARB_STATS_EN
    logic [31:0] rd_count_q, wr_count_q;
    logic [15:0] raw_wait_q, max_wait_q;

    // raw_wait_q mirrors the wait counter but is not capped at the starve limit.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
            raw_wait_q <= '0;
            max_wait_q <= '0;
        end else begin
            if (state_q == ARB_READ) begin
                rd_count_q <= rd_count_q + 32'd1;
            end
            if (state_q == ARB_WRITE) begin
                wr_count_q <= wr_count_q + 32'd1;
            end
            if (!wr_req || wr_gnt) begin
                raw_wait_q <= '0;
            end else if (raw_wait_q != 16'hFFFF) begin
                raw_wait_q <= raw_wait_q + 16'd1;
            end
            if (raw_wait_q > max_wait_q) begin
                max_wait_q <= raw_wait_q;
            end
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
    assign max_wait = max_wait_q;
`endif

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Scoreboard bench for vga_mem_arbiter: a cycle-rule reference model predicts pins,
// grants and read returns; an SRAM model answers the memory pins.
module tb_vga_mem_arbiter;

    localparam int AW    = 20;
    localparam int DW    = 16;
    localparam int LAT   = 2;
    localparam int LIMIT = 64;

    localparam int K_IDLE  = 0;
    localparam int K_READ  = 1;
    localparam int K_WRITE = 2;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_rvalid;
    logic [DW-1:0] disp_rdata;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_gnt;
    logic          wr_starve;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ce_n, mem_oe_n, mem_we_n;
`ifdef VGA_MEM_ARB_STATS_EN
    logic [31:0]   rd_count, wr_count;
    logic [15:0]   max_wait;
`endif

    vga_mem_arbiter dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .disp_req    (disp_req),
        .disp_addr   (disp_addr),
        .disp_rvalid (disp_rvalid),
        .disp_rdata  (disp_rdata),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_gnt      (wr_gnt),
        .wr_starve   (wr_starve),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ce_n    (mem_ce_n),
        .mem_oe_n    (mem_oe_n),
        .mem_we_n    (mem_we_n)
`ifdef VGA_MEM_ARB_STATS_EN
        ,
        .rd_count    (rd_count),
        .wr_count    (wr_count),
        .max_wait    (max_wait)
`endif
    );

    always #10 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        int            kind;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            starve;
    } pin_exp_t;

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
    } rd_exp_t;

    pin_exp_t      pinQ[$];
    rd_exp_t       rdQ[$];
    int            gntQ[$];
    logic [DW-1:0] refMem[int];
    logic [DW-1:0] sram[int];
    logic [DW-1:0] hist[LAT];

    int assertCount = 0;
    int failCount   = 0;

    // Reference model state: what the spec rules say the arbiter should be doing.
    bit            modelGnt   = 0;
    int            modelWait  = 0;
    int            modelRaw   = 0;
    int            maxWait    = 0;
    int            nRd        = 0;
    int            nWr        = 0;

    // Writer stimulus state: holds its request until the grant cycle has passed.
    bit            wrActive   = 0;
    int            wrGrantCyc = -1;
    logic [AW-1:0] wrA        = '0;
    logic [DW-1:0] wrD        = '0;

    function automatic logic [DW-1:0] fillWord(input int a);
        return DW'((a * 40503) ^ 23130);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic queueWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wrActive   = 1;
        wrGrantCyc = -1;
        wrA        = a;
        wrD        = d;
    endtask

    // One clock of stimulus; the model predicts the pin cycle that follows it.
    task automatic applyStimulus(input bit rst, input bit dreq, input logic [AW-1:0] daddr);
        int       n;
        int       key;
        bit       wreq;
        bit       nextGnt;
        pin_exp_t e;
        rd_exp_t  r;
        rd_exp_t  keep[$];
        @(posedge Clk);
        #1;
        n         = cyc;
        wreq      = wrActive && !rst;
        Reset     = rst;
        disp_req  = dreq;
        disp_addr = daddr;
        wr_req    = wreq;
        wr_addr   = wrA;
        wr_data   = wrD;
        e.cyc     = n + 1;
        e.kind    = K_IDLE;
        e.addr    = '0;
        e.data    = '0;
        e.starve  = 0;
        if (rst) begin
            keep = {};
            foreach (rdQ[i]) if (rdQ[i].cyc <= n) keep.push_back(rdQ[i]);
            rdQ       = keep;
            wrActive  = 0;
            modelGnt  = 0;
            modelWait = 0;
            modelRaw  = 0;
            maxWait   = 0;
            nRd       = 0;
            nWr       = 0;
        end else begin
            if (modelRaw > maxWait) maxWait = modelRaw;
            if (!wreq || modelGnt) begin
                modelWait = 0;
                modelRaw  = 0;
            end else begin
                if (modelWait < LIMIT) modelWait++;
                if (modelRaw < 65535) modelRaw++;
            end
            nextGnt = 0;
            if (dreq) begin
                e.kind = K_READ;
                e.addr = daddr;
                key    = int'(daddr);
                r.cyc  = n + 1 + LAT;
                r.data = refMem.exists(key) ? refMem[key] : fillWord(key);
                rdQ.push_back(r);
                nRd++;
            end else if (wreq && !modelGnt) begin
                e.kind = K_WRITE;
                e.addr = wrA;
                e.data = wrD;
                refMem[int'(wrA)] = wrD;
                gntQ.push_back(n + 1);
                wrGrantCyc = n + 1;
                nWr++;
                nextGnt = 1;
            end
            e.starve = (modelWait == LIMIT);
            modelGnt = nextGnt;
            if (wrActive && wrGrantCyc == n) wrActive = 0;
        end
        pinQ.push_back(e);
    endtask

    // SRAM environment: returns read data LAT-1 cycles after the read pin cycle.
    always @(negedge Clk) begin
        logic [DW-1:0] d;
        int            a;
        d = DW'($urandom);
        a = int'(mem_addr);
        if (mem_ce_n === 1'b0 && mem_oe_n === 1'b0 && mem_we_n === 1'b1)
            d = sram.exists(a) ? sram[a] : fillWord(a);
        if (mem_ce_n === 1'b0 && mem_we_n === 1'b0)
            sram[a] = mem_wdata;
        for (int i = LAT - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0]   = d;
        mem_rdata = hist[LAT-1];
    end

    // Monitor: pops expectations whenever the DUT presents a pin cycle, rvalid or grant.
    always @(negedge Clk) begin
        pin_exp_t    e;
        rd_exp_t     r;
        int          g;
        logic [2:0]  ctl;
        while (pinQ.size() > 0 && pinQ[0].cyc < cyc) void'(pinQ.pop_front());
        if (pinQ.size() > 0 && pinQ[0].cyc == cyc) begin
            e   = pinQ.pop_front();
            ctl = (e.kind == K_READ) ? 3'b001 : (e.kind == K_WRITE) ? 3'b010 : 3'b111;
            checkOutput("mem_ce_oe_we", {29'd0, mem_ce_n, mem_oe_n, mem_we_n}, {29'd0, ctl});
            if (e.kind != K_IDLE) checkOutput("mem_addr", 32'(mem_addr), 32'(e.addr));
            if (e.kind == K_WRITE) checkOutput("mem_wdata", 32'(mem_wdata), 32'(e.data));
            checkOutput("wr_starve", 32'(wr_starve), 32'(e.starve));
            checkOutput("wr_gnt_level", 32'(wr_gnt), 32'(e.kind == K_WRITE));
        end
        if (disp_rvalid === 1'b1) begin
            checkOutput("rvalid_expected", 32'(rdQ.size() > 0), 32'd1);
            if (rdQ.size() > 0) begin
                r = rdQ.pop_front();
                checkOutput("rvalid_cycle", cyc, r.cyc);
                checkOutput("disp_rdata", 32'(disp_rdata), 32'(r.data));
            end
        end
        while (rdQ.size() > 0 && rdQ[0].cyc < cyc) begin
            checkOutput("rvalid_missing_cycle", cyc, rdQ[0].cyc);
            void'(rdQ.pop_front());
        end
        if (wr_gnt === 1'b1) begin
            checkOutput("gnt_expected", 32'(gntQ.size() > 0), 32'd1);
            if (gntQ.size() > 0) begin
                g = gntQ.pop_front();
                checkOutput("wr_gnt_cycle", cyc, g);
            end
        end
        while (gntQ.size() > 0 && gntQ[0] < cyc) begin
            checkOutput("wr_gnt_missing_cycle", cyc, gntQ[0]);
            void'(gntQ.pop_front());
        end
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int dens;
        Reset     = 1'b1;
        disp_req  = 1'b0;
        disp_addr = '0;
        wr_req    = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;

        repeat (3) applyStimulus(1, 0, '0);
        @(negedge Clk);
        checkOutput("reset_ce_n", 32'(mem_ce_n), 32'd1);
        checkOutput("reset_oe_n", 32'(mem_oe_n), 32'd1);
        checkOutput("reset_we_n", 32'(mem_we_n), 32'd1);
        checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("reset_mem_wdata", 32'(mem_wdata), 32'd0);
        checkOutput("reset_disp_rvalid", 32'(disp_rvalid), 32'd0);
        checkOutput("reset_disp_rdata", 32'(disp_rdata), 32'd0);
        checkOutput("reset_wr_gnt", 32'(wr_gnt), 32'd0);
        checkOutput("reset_wr_starve", 32'(wr_starve), 32'd0);

        repeat (4) applyStimulus(0, 0, '0);

        $display("[TB] single read");
        applyStimulus(0, 1, 20'h00123);
        repeat (5) applyStimulus(0, 0, '0);

        $display("[TB] reset during an in-flight read");
        applyStimulus(0, 1, 20'h00055);
        applyStimulus(1, 0, '0);
        repeat (6) applyStimulus(0, 0, '0);

        $display("[TB] write contending with pixel-rate reads");
        queueWrite(20'h00400, 16'hBEEF);
        for (int i = 0; i < 12; i++) applyStimulus(0, (i % 2) == 0, AW'(20'h00100 + i));
        repeat (4) applyStimulus(0, 0, '0);

        $display("[TB] held write with idle display");
        queueWrite(20'h00777, 16'h1234);
        repeat (6) applyStimulus(0, 0, '0);
        applyStimulus(0, 1, 20'h00777);
        applyStimulus(0, 1, 20'h00400);
        repeat (4) applyStimulus(0, 0, '0);

        $display("[TB] write withdrawn before grant");
        queueWrite(20'h00888, 16'hAAAA);
        repeat (3) applyStimulus(0, 1, 20'h00010);
        wrActive = 0;
        repeat (2) applyStimulus(0, 0, '0);
        applyStimulus(0, 1, 20'h00888);
        repeat (4) applyStimulus(0, 0, '0);

        $display("[TB] starvation under continuous reads");
        queueWrite(20'h00999, 16'h5555);
        for (int i = 0; i < 100; i++) applyStimulus(0, 1, AW'(i));
        repeat (6) applyStimulus(0, 0, '0);
        applyStimulus(0, 1, 20'h00999);
        repeat (4) applyStimulus(0, 0, '0);

        $display("[TB] randomized traffic");
        dens = 50;
        for (int i = 0; i < 1500; i++) begin
            if (i % 150 == 0) dens = $urandom_range(0, 100);
            if (!wrActive && ($urandom % 4) == 0)
                queueWrite(AW'($urandom_range(0, 63)), DW'($urandom));
            else if (wrActive && wrGrantCyc < 0 && ($urandom % 40) == 0)
                wrActive = 0;
            applyStimulus(($urandom % 600) == 0, ($urandom % 100) < dens,
                          AW'($urandom_range(0, 63)));
        end

        repeat (10) applyStimulus(0, 0, '0);
        @(negedge Clk);
        #1;
        checkOutput("rd_queue_drained", 32'(rdQ.size()), 32'd0);
        checkOutput("gnt_queue_drained", 32'(gntQ.size()), 32'd0);
`ifdef VGA_MEM_ARB_STATS_EN
        checkOutput("rd_count", rd_count, 32'(nRd));
        checkOutput("wr_count", wr_count, 32'(nWr));
        checkOutput("max_wait", 32'(max_wait), 32'(maxWait));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
